// File: rtl/mc_control.sv
// Multicycle RISC-V control unit: instruction-sequencing FSM plus ALU and immediate decode.
// Only the state register is clocked; every control output is decoded from it combinationally.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       EQ,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pcwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic [2:0] w_alu_fn;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Next-state decode; unused encodings fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_JAL:       w_next = S_JAL;
          OP_BR:        w_next = S_BRANCH;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  // ALU function; only R-type honours funct7b5 to select SUB.
  always_comb begin
    w_alu_fn = 3'b000;
    case (funct3)
      3'b000:  w_alu_fn = ((r_state == S_EXECUTER) && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  w_alu_fn = 3'b101;
      3'b110:  w_alu_fn = 3'b011;
      3'b111:  w_alu_fn = 3'b010;
      default: w_alu_fn = 3'b000;
    endcase
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu_fn;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu_fn;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        case (funct3)
          3'b000:  w_pcwrite = EQ;
          3'b001:  w_pcwrite = ~EQ;
          default: w_pcwrite = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Architectural writes are suppressed for as long as reset is held.
  assign PCWrite  = w_pcwrite  & ~rst;
  assign IRWrite  = w_irwrite  & ~rst;
  assign RegWrite = w_regwrite & ~rst;
  assign MemWrite = w_memwrite & ~rst;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: each instruction class is expanded into its expected
// state walk and per-cycle control word, and compared cycle by cycle against the DUT.
module tb_mc_control;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       EQ;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111;

  mc_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .EQ(EQ),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire logic [15:0] dut_ctrl = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (op=%b f3=%b f7=%b EQ=%b t=%0t)",
               tag, obs, exp, op, funct3, funct7b5, EQ, $time);
    end
  endtask

  // Expected control word for one cycle, written straight from the per-state output table.
  function automatic logic [15:0] model_ctrl(input int s, input logic [6:0] o,
                                              input logic [2:0] f3, input logic f7,
                                              input logic eq);
    logic pcw, irw, rw, mw, adr;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu, fn;
    {pcw, irw, rw, mw, adr} = 5'b0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    if (f3 == 3'b010)      fn = 3'b101;
    else if (f3 == 3'b110) fn = 3'b011;
    else if (f3 == 3'b111) fn = 3'b010;
    else if (f3 == 3'b000 && s == 6 && f7) fn = 3'b001;
    else                   fn = 3'b000;
    if (s == 0)       begin irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10; end
    else if (s == 1)  begin sa = 2'b01; sb = 2'b01; end
    else if (s == 2)  begin sa = 2'b10; sb = 2'b01; end
    else if (s == 3)  adr = 1;
    else if (s == 4)  begin rs = 2'b01; rw = 1; end
    else if (s == 5)  begin adr = 1; mw = 1; end
    else if (s == 6)  begin sa = 2'b10; alu = fn; end
    else if (s == 7)  rw = 1;
    else if (s == 8)  begin sa = 2'b10; sb = 2'b01; alu = fn; end
    else if (s == 9)  begin sa = 2'b01; sb = 2'b10; pcw = 1; end
    else if (s == 10) begin
      sa = 2'b10; alu = 3'b001;
      pcw = (f3 == 3'b000) ? eq : (f3 == 3'b001) ? ~eq : 1'b0;
    end
    imm = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
    return {pcw, irw, rw, mw, adr, rs, sa, sb, alu, imm};
  endfunction

  // One cycle: optionally load the instruction fields during FETCH, drive EQ, then compare.
  task automatic step(input int exp_s, input int eqmode, input bit load);
    @(negedge clk);
    if (load) begin op = cur_op; funct3 = cur_f3; funct7b5 = cur_f7; end
    EQ = (eqmode == 2) ? 1'($urandom) : 1'(eqmode);
    #1;
    check_eq("state", 32'(state), 32'(exp_s));
    check_eq("ctrl", 32'(dut_ctrl), 32'(model_ctrl(exp_s, cur_op, cur_f3, cur_f7, EQ)));
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int eqmode);
    int seq[$];
    cur_op = o; cur_f3 = f3; cur_f7 = f7;
    case (o)
      LW:      seq = '{0, 1, 2, 3, 4};
      SW:      seq = '{0, 1, 2, 5};
      RT:      seq = '{0, 1, 6, 7};
      IT:      seq = '{0, 1, 8, 7};
      JL:      seq = '{0, 1, 9, 7};
      BR:      seq = '{0, 1, 10};
      default: seq = '{0, 1};
    endcase
    foreach (seq[i]) step(seq[i], eqmode, i == 0);
  endtask

  initial begin
    logic [6:0] ops [7];
    ops = '{LW, SW, RT, IT, JL, BR, LUI};
    rst = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; EQ = 1'b0;
    cur_op = '0; cur_f3 = '0; cur_f7 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_wen", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed cases.
    run_instr(LW, 3'b010, 1'b0, 2);
    run_instr(RT, 3'b000, 1'b1, 2);
    run_instr(IT, 3'b000, 1'b1, 2);
    run_instr(BR, 3'b000, 1'b0, 1);
    run_instr(BR, 3'b000, 1'b0, 0);
    run_instr(BR, 3'b001, 1'b0, 1);
    run_instr(BR, 3'b001, 1'b0, 0);
    run_instr(LUI, 3'b000, 1'b0, 2);
    run_instr(RT, 3'b010, 1'b0, 2);
    run_instr(RT, 3'b110, 1'b0, 2);
    run_instr(RT, 3'b111, 1'b0, 2);
    run_instr(JL, 3'b000, 1'b0, 2);
    run_instr(SW, 3'b010, 1'b0, 2);

    // Reset asserted for one cycle while in MEMWRITE.
    cur_op = SW; cur_f3 = 3'b010; cur_f7 = 1'b0;
    step(0, 2, 1); step(1, 2, 0); step(2, 2, 0);
    @(negedge clk); rst = 1'b1; #1;
    check_eq("rst_mid_state", 32'(state), 32'd5);
    check_eq("rst_mid_memwrite", 32'(MemWrite), 32'd0);
    check_eq("rst_mid_wen", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_instr(LW, 3'b010, 1'b0, 2);

    // Random instruction stream.
    for (int k = 0; k < 300; k++) begin
      int sel;
      logic [6:0] o;
      sel = int'($urandom_range(0, 7));
      o = (sel == 7) ? 7'($urandom) : ops[sel];
      run_instr(o, 3'($urandom), 1'($urandom), 2);
    end
    step(0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
